mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the packed execute control bus and performs LA32R loads and stores against a req/ack data-memory port.
- Forms the write-back value and presents a packed bus to write-back under the same valid/ready handshake used across the pipeline.
- Multi-cycle memory accesses stall the upstream stage through left_ready.

Parameters:
- EX_W, 213, width of input bus: alu_op[212:199], inst_valid[198], imm[197:166], pc[165:134], inst[133:102], wreg_index[101:97], wreg_en[96], src2/store data[95:64], src1[63:32], alu_result/address[31:0]
- MEM_W, 104, width of output bus: ale[103], inst_valid[102], pc[101:70], inst[69:38], wreg_index[37:33], wreg_en[32], wdata[31:0]

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_ctrl_bus  in  EX_W  execute-stage payload
- left_valid  in  1  execute payload valid
- left_ready  out  1  this stage accepts a payload
- mem_ctrl_bus  out  MEM_W  registered write-back payload
- right_valid  out  1  mem_ctrl_bus valid
- right_ready  in  1  write-back accepts
- data_req  out  1  memory request, held until data_ack
- data_wstrb  out  4  byte write strobes; 0 = read
- data_addr  out  32  word-aligned address (alu_result & ~3)
- data_wdata  out  32  store data replicated into lanes
- data_ack  in  1  request completed this cycle
- data_rdata  in  32  read word, valid with data_ack

Behaviour:
- Decode uses inst[31:22]:
  - ld.b 0x0A0, ld.h 0x0A1, ld.w 0x0A2, ld.bu 0x0A8, ld.hu 0x0A9
  - st.b 0x0A4, st.h 0x0A5, st.w 0x0A6
  - any other opcode is non-memory.
- Misalignment (ale):
  - h access with addr[0]=1 is misaligned.
  - w access with addr[1:0]!=0 is misaligned.
  - A misaligned op issues no request, forces wreg_en=0, sets ale=1, and goes straight to FULL.
- FSM states: EMPTY, ACCESS, FULL. Reset enters EMPTY; all registers and outputs are 0, data_req=0.
- left_ready = (state==EMPTY) | (state==FULL & right_ready). It is 0 in ACCESS.
- Accept = left_valid & left_ready:
  - Payload fields are captured.
  - An aligned memory op goes to ACCESS.
  - Any other payload goes to FULL, with wdata = alu_result.
- ACCESS:
  - data_req=1; data_addr, data_wstrb and data_wdata are driven from registered fields and stay stable until ack.
  - On data_ack, go to FULL. For loads, wdata = the selected byte/half/word, sign- or zero-extended per opcode. For stores, wdata = 0 and wreg_en is forced 0.
  - Without ack, remain in ACCESS indefinitely.
- FULL:
  - right_valid=1.
  - If right_ready and a new accept occur in the same cycle, load the new payload with no bubble.
  - If right_ready without an accept, go to EMPTY.
  - Otherwise hold mem_ctrl_bus unchanged.
- Strobes and lanes:
  - st.b: wstrb = 1<<addr[1:0], data = {4{src2[7:0]}}.
  - st.h: wstrb = 4'b0011 << addr[1:0], data = {2{src2[15:0]}}.
  - st.w: wstrb = 4'hF, data = src2.
- Latency:
  - Non-memory op accepted in cycle N: right_valid in N+1.
  - Memory op: data_req asserted in N+1; data_ack in cycle M gives right_valid in M+1. Minimum 2 cycles.
- right_valid is never asserted in EMPTY or ACCESS.
- data_ack outside ACCESS is ignored.
- Reset mid-ACCESS returns to EMPTY and drops data_req the next cycle. The outstanding transaction is abandoned.
- inst_valid=0 payloads flow through as non-memory, with wreg_en passed through unchanged.

Test Plan:
- Reset, then add result: bus with inst opcode 0x000, alu_result=0x1234, wreg_en=1, index 5, right_ready=1 -> right_valid next cycle, wdata=0x1234, wreg_index=5, data_req never high.
- ld.b at 0x1003 with ack after 3 cycles: data_req held 3 cycles, data_addr=0x1000, data_wstrb=0, left_ready=0 throughout; data_rdata=0x80FFFFFF -> wdata=0xFFFFFF80; the same access as ld.bu -> wdata=0x00000080.
- st.h at 0x2002, src2=0xABCD1234: data_wstrb=4'b1100, data_wdata=0x12341234; output wreg_en=0.
- ld.w at 0x3001 -> no data_req, right_valid next cycle, ale=1, wreg_en=0.
- Back-to-back non-memory ops with right_ready=1 -> one result per cycle, left_ready stays 1. Then right_ready=0 for 4 cycles -> mem_ctrl_bus stable, left_ready=0.
- Assert reset during ACCESS -> data_req=0, right_valid=0 next cycle; a late data_ack is ignored.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: LA32R memory stage. Takes the packed execute bus, performs
// loads/stores over a req/ack data-memory port, and hands a packed result
// bus to write-back under a valid/ready handshake. While a memory access is
// outstanding the upstream stage is held off through left_ready.
module mem_stage #(
    parameter int EX_W  = 213,
    parameter int MEM_W = 104
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [EX_W-1:0]  ex_ctrl_bus,
    input  logic             left_valid,
    output logic             left_ready,
    output logic [MEM_W-1:0] mem_ctrl_bus,
    output logic             right_valid,
    input  logic             right_ready,
    output logic             data_req,
    output logic [3:0]       data_wstrb,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    input  logic             data_ack,
    input  logic [31:0]      data_rdata
);

    localparam logic [9:0] OP_LD_B  = 10'h0A0;
    localparam logic [9:0] OP_LD_H  = 10'h0A1;
    localparam logic [9:0] OP_LD_W  = 10'h0A2;
    localparam logic [9:0] OP_LD_BU = 10'h0A8;
    localparam logic [9:0] OP_LD_HU = 10'h0A9;
    localparam logic [9:0] OP_ST_B  = 10'h0A4;
    localparam logic [9:0] OP_ST_H  = 10'h0A5;
    localparam logic [9:0] OP_ST_W  = 10'h0A6;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_ACCESS = 2'd1,
        S_FULL   = 2'd2
    } state_t;

    state_t state, next_state;

    // Execute-bus fields used by this stage.
    logic        ex_inst_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_inst;
    logic [4:0]  ex_wreg_index;
    logic        ex_wreg_en;
    logic [31:0] ex_src2;
    logic [31:0] ex_alu_result;
    logic        ex_unused;

    assign ex_inst_valid = ex_ctrl_bus[198];
    assign ex_pc         = ex_ctrl_bus[165:134];
    assign ex_inst       = ex_ctrl_bus[133:102];
    assign ex_wreg_index = ex_ctrl_bus[101:97];
    assign ex_wreg_en    = ex_ctrl_bus[96];
    assign ex_src2       = ex_ctrl_bus[95:64];
    assign ex_alu_result = ex_ctrl_bus[31:0];
    assign ex_unused     = ^{ex_ctrl_bus[212:199], ex_ctrl_bus[197:166], ex_ctrl_bus[63:32]};

    // Decoded view of the incoming payload.
    logic       dec_load;
    logic       dec_store;
    logic       dec_unsigned;
    logic [1:0] dec_size;
    logic       dec_misaligned;
    logic       dec_go_access;
    logic [3:0] dec_wstrb;
    logic [31:0] dec_wdata;

    // Registered payload and access context.
    logic        q_ale;
    logic        q_inst_valid;
    logic [31:0] q_pc;
    logic [31:0] q_inst;
    logic [4:0]  q_wreg_index;
    logic        q_wreg_en;
    logic [31:0] q_wdata;
    logic [29:0] q_addr_word;
    logic [1:0]  q_byte_off;
    logic [3:0]  q_wstrb;
    logic [31:0] q_store_data;
    logic [1:0]  q_size;
    logic        q_unsigned;
    logic        q_is_store;

    logic        accept;
    logic        in_access;
    logic [31:0] load_value;

    assign in_access  = (state == S_ACCESS);
    assign left_ready = (state == S_EMPTY) | ((state == S_FULL) & right_ready);
    assign accept     = left_valid & left_ready;

    // Opcode decode, alignment check and store lane/strobe formation.
    always_comb begin
        dec_load       = 1'b0;
        dec_store      = 1'b0;
        dec_unsigned   = 1'b0;
        dec_size       = SZ_WORD;
        dec_misaligned = 1'b0;
        dec_wstrb      = 4'b0000;
        dec_wdata      = 32'h0;
        if (ex_inst_valid) begin
            unique case (ex_inst[31:22])
                OP_LD_B:  begin dec_load  = 1'b1; dec_size = SZ_BYTE; end
                OP_LD_H:  begin dec_load  = 1'b1; dec_size = SZ_HALF; end
                OP_LD_W:  begin dec_load  = 1'b1; dec_size = SZ_WORD; end
                OP_LD_BU: begin dec_load  = 1'b1; dec_size = SZ_BYTE; dec_unsigned = 1'b1; end
                OP_LD_HU: begin dec_load  = 1'b1; dec_size = SZ_HALF; dec_unsigned = 1'b1; end
                OP_ST_B:  begin dec_store = 1'b1; dec_size = SZ_BYTE; end
                OP_ST_H:  begin dec_store = 1'b1; dec_size = SZ_HALF; end
                OP_ST_W:  begin dec_store = 1'b1; dec_size = SZ_WORD; end
                default:  begin end
            endcase
        end
        if (dec_load | dec_store) begin
            if (dec_size == SZ_HALF) begin
                dec_misaligned = ex_alu_result[0];
            end else if (dec_size == SZ_WORD) begin
                dec_misaligned = (ex_alu_result[1:0] != 2'b00);
            end
        end
        if (dec_store) begin
            unique case (dec_size)
                SZ_BYTE: begin
                    dec_wstrb = 4'b0001 << ex_alu_result[1:0];
                    dec_wdata = {4{ex_src2[7:0]}};
                end
                SZ_HALF: begin
                    dec_wstrb = 4'b0011 << ex_alu_result[1:0];
                    dec_wdata = {2{ex_src2[15:0]}};
                end
                default: begin
                    dec_wstrb = 4'b1111;
                    dec_wdata = ex_src2;
                end
            endcase
        end
    end

    assign dec_go_access = (dec_load | dec_store) & ~dec_misaligned;

    // Extract and extend the addressed byte/half/word from the read data.
    always_comb begin
        logic [31:0] lane;
        lane       = data_rdata >> {q_byte_off, 3'b000};
        load_value = data_rdata;
        unique case (q_size)
            SZ_BYTE: load_value = q_unsigned ? {24'h0, lane[7:0]}
                                             : {{24{lane[7]}}, lane[7:0]};
            SZ_HALF: load_value = q_unsigned ? {16'h0, lane[15:0]}
                                             : {{16{lane[15]}}, lane[15:0]};
            default: load_value = data_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; FULL can reload directly to avoid a bubble.
    always_comb begin
        next_state = state;
        unique case (state)
            S_EMPTY: begin
                if (accept) begin
                    next_state = dec_go_access ? S_ACCESS : S_FULL;
                end
            end
            S_ACCESS: begin
                if (data_ack) begin
                    next_state = S_FULL;
                end
            end
            S_FULL: begin
                if (accept) begin
                    next_state = dec_go_access ? S_ACCESS : S_FULL;
                end else if (right_ready) begin
                    next_state = S_EMPTY;
                end
            end
            default: next_state = S_EMPTY;
        endcase
    end

    // Payload capture on accept, write-back value update on memory ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_ale        <= 1'b0;
            q_inst_valid <= 1'b0;
            q_pc         <= 32'h0;
            q_inst       <= 32'h0;
            q_wreg_index <= 5'h0;
            q_wreg_en    <= 1'b0;
            q_wdata      <= 32'h0;
            q_addr_word  <= 30'h0;
            q_byte_off   <= 2'b00;
            q_wstrb      <= 4'b0000;
            q_store_data <= 32'h0;
            q_size       <= SZ_BYTE;
            q_unsigned   <= 1'b0;
            q_is_store   <= 1'b0;
        end else if (accept) begin
            q_ale        <= dec_misaligned;
            q_inst_valid <= ex_inst_valid;
            q_pc         <= ex_pc;
            q_inst       <= ex_inst;
            q_wreg_index <= ex_wreg_index;
            q_wreg_en    <= ex_wreg_en & ~dec_misaligned & ~dec_store;
            q_wdata      <= ex_alu_result;
            q_addr_word  <= ex_alu_result[31:2];
            q_byte_off   <= ex_alu_result[1:0];
            q_wstrb      <= dec_wstrb;
            q_store_data <= dec_wdata;
            q_size       <= dec_size;
            q_unsigned   <= dec_unsigned;
            q_is_store   <= dec_store;
        end else if (in_access && data_ack) begin
            q_wdata      <= q_is_store ? 32'h0 : load_value;
        end
    end

    // Memory port is only driven while an access is outstanding.
    always_comb begin
        data_req   = in_access;
        data_addr  = in_access ? {q_addr_word, 2'b00} : 32'h0;
        data_wstrb = in_access ? q_wstrb : 4'b0000;
        data_wdata = in_access ? q_store_data : 32'h0;
    end

    assign right_valid  = (state == S_FULL);
    assign mem_ctrl_bus = {q_ale, q_inst_valid, q_pc, q_inst, q_wreg_index, q_wreg_en, q_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage, directed scenarios plus
// randomized transactions compared against a behavioural model of the stage.
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic [212:0] ex_ctrl_bus;
    logic         left_valid;
    logic         left_ready;
    logic [103:0] mem_ctrl_bus;
    logic         right_valid;
    logic         right_ready;
    logic         data_req;
    logic [3:0]   data_wstrb;
    logic [31:0]  data_addr;
    logic [31:0]  data_wdata;
    logic         data_ack;
    logic [31:0]  data_rdata;

    int pass_count;
    int total_count;

    mem_stage #(.EX_W(213), .MEM_W(104)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_ctrl_bus  (ex_ctrl_bus),
        .left_valid   (left_valid),
        .left_ready   (left_ready),
        .mem_ctrl_bus (mem_ctrl_bus),
        .right_valid  (right_valid),
        .right_ready  (right_ready),
        .data_req     (data_req),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_ack     (data_ack),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         mem;
        logic [3:0]   strb;
        logic [31:0]  addr;
        logic [31:0]  wdm;
        logic [103:0] bus;
    } exp_t;

    function automatic logic [212:0] make_bus(input logic [9:0] op, input logic iv,
                                              input logic [31:0] pc, input logic [4:0] idx,
                                              input logic wen, input logic [31:0] src2,
                                              input logic [31:0] alu);
        logic [31:0] inst;
        inst = {op, 22'h12345};
        return {14'h2A5, iv, 32'hDEAD0000, pc, inst, idx, wen, src2, 32'hC0FFEE00, alu};
    endfunction

    // What the stage should do with one payload, from the LA32R rules.
    function automatic exp_t model(input logic [212:0] b, input logic [31:0] rdata);
        exp_t e;
        logic [31:0] inst, alu, src2, wd, lane, mask;
        int op, nbytes, off;
        logic iv, wen, is_ld, is_st, sgn, mis;
        inst = b[133:102]; alu = b[31:0]; src2 = b[95:64];
        iv = b[198]; wen = b[96];
        op = int'(inst[31:22]);
        is_ld = 0; is_st = 0; sgn = 0; nbytes = 4;
        if (iv) begin
            case (op)
                'h0A0: begin is_ld = 1; nbytes = 1; sgn = 1; end
                'h0A1: begin is_ld = 1; nbytes = 2; sgn = 1; end
                'h0A2: begin is_ld = 1; nbytes = 4; end
                'h0A8: begin is_ld = 1; nbytes = 1; end
                'h0A9: begin is_ld = 1; nbytes = 2; end
                'h0A4: begin is_st = 1; nbytes = 1; end
                'h0A5: begin is_st = 1; nbytes = 2; end
                'h0A6: begin is_st = 1; nbytes = 4; end
                default: ;
            endcase
        end
        off = int'(alu % 4);
        mis = (is_ld || is_st) && (off % nbytes != 0);
        e.mem  = (is_ld || is_st) && !mis;
        e.addr = alu - 32'(off);
        e.strb = 0; e.wdm = 0;
        wd = alu;
        if (is_st && e.mem) begin
            e.strb = 4'((nbytes == 4) ? 15 : (((1 << nbytes) - 1) << off));
            if (nbytes == 1) e.wdm = (src2 % 256) * 32'h01010101;
            else if (nbytes == 2) e.wdm = (src2 % 65536) * 32'h00010001;
            else e.wdm = src2;
            wd = 0;
        end
        if (is_ld && e.mem) begin
            lane = rdata >> (8 * off);
            if (nbytes == 4) wd = rdata;
            else begin
                mask = (nbytes == 1) ? 32'hFF : 32'hFFFF;
                wd = lane & mask;
                if (sgn && wd >= (mask + 1) / 2) wd = wd | ~mask;
            end
        end
        if (is_st || mis) wen = 0;
        e.bus = {mis, iv, b[165:134], inst, b[101:97], wen, wd};
        return e;
    endfunction

    task automatic test_reset();
        reset = 1; left_valid = 0; right_ready = 0; data_ack = 0;
        data_rdata = 0; ex_ctrl_bus = 0;
        repeat (2) @(posedge clk);
        #1;
        total_count++;
        if ({right_valid, data_req, left_ready} !== 3'b001)
            $display("[TB] FAIL reset_ctrl got rv/req/lr=%b want 001", {right_valid, data_req, left_ready});
        else pass_count++;
        total_count++;
        if (mem_ctrl_bus !== 104'h0 || data_wstrb !== 4'h0 || data_addr !== 32'h0)
            $display("[TB] FAIL reset_bus got %h want 0", mem_ctrl_bus);
        else pass_count++;
        reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        exp_t e;
        ex_ctrl_bus = make_bus(10'h000, 1'b1, 32'h1C000000, 5'd5, 1'b1, 32'h0, 32'h1234);
        e = model(ex_ctrl_bus, 32'h0);
        right_ready = 1; left_valid = 1;
        @(posedge clk); #1;
        left_valid = 0;
        total_count++;
        if (right_valid !== 1'b1 || data_req !== 1'b0)
            $display("[TB] FAIL add_valid got rv=%b req=%b want rv=1 req=0", right_valid, data_req);
        else pass_count++;
        total_count++;
        if (mem_ctrl_bus[31:0] !== 32'h1234 || mem_ctrl_bus[37:33] !== 5'd5 || mem_ctrl_bus !== e.bus)
            $display("[TB] FAIL add_bus got %h want %h", mem_ctrl_bus, e.bus);
        else pass_count++;
        @(posedge clk); #1;
    endtask

    task automatic test_load_byte();
        logic [9:0] ops [2];
        logic [31:0] want [2];
        ops[0] = 10'h0A0; ops[1] = 10'h0A8;
        want[0] = 32'hFFFFFF80; want[1] = 32'h00000080;
        right_ready = 1;
        for (int k = 0; k < 2; k++) begin
            ex_ctrl_bus = make_bus(ops[k], 1'b1, 32'h100, 5'd7, 1'b1, 32'h0, 32'h1003);
            left_valid = 1;
            @(posedge clk); #1;
            left_valid = 0;
            for (int i = 0; i < 3; i++) begin
                total_count++;
                if (data_req !== 1'b1 || data_addr !== 32'h1000 || data_wstrb !== 4'h0 ||
                    left_ready !== 1'b0 || right_valid !== 1'b0)
                    $display("[TB] FAIL ldb_access got req=%b addr=%h strb=%h lr=%b rv=%b want 1 00001000 0 0 0",
                             data_req, data_addr, data_wstrb, left_ready, right_valid);
                else pass_count++;
                if (i == 2) begin data_ack = 1; data_rdata = 32'h80FFFFFF; end
                @(posedge clk); #1;
            end
            data_ack = 0;
            total_count++;
            if (right_valid !== 1'b1 || mem_ctrl_bus[31:0] !== want[k] || mem_ctrl_bus[32] !== 1'b1)
                $display("[TB] FAIL ldb_result got rv=%b wdata=%h want rv=1 wdata=%h",
                         right_valid, mem_ctrl_bus[31:0], want[k]);
            else pass_count++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_half();
        ex_ctrl_bus = make_bus(10'h0A5, 1'b1, 32'h200, 5'd9, 1'b1, 32'hABCD1234, 32'h2002);
        left_valid = 1; right_ready = 1;
        @(posedge clk); #1;
        left_valid = 0;
        total_count++;
        if (data_req !== 1'b1 || data_wstrb !== 4'b1100 || data_wdata !== 32'h12341234 || data_addr !== 32'h2000)
            $display("[TB] FAIL sth_port got strb=%b wdata=%h addr=%h want 1100 12341234 00002000",
                     data_wstrb, data_wdata, data_addr);
        else pass_count++;
        data_ack = 1;
        @(posedge clk); #1;
        data_ack = 0;
        total_count++;
        if (right_valid !== 1'b1 || mem_ctrl_bus[32] !== 1'b0 || mem_ctrl_bus[31:0] !== 32'h0)
            $display("[TB] FAIL sth_result got rv=%b wen=%b wdata=%h want 1 0 0",
                     right_valid, mem_ctrl_bus[32], mem_ctrl_bus[31:0]);
        else pass_count++;
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned();
        ex_ctrl_bus = make_bus(10'h0A2, 1'b1, 32'h300, 5'd3, 1'b1, 32'h0, 32'h3001);
        left_valid = 1; right_ready = 1;
        @(posedge clk); #1;
        left_valid = 0;
        total_count++;
        if (data_req !== 1'b0 || right_valid !== 1'b1 || mem_ctrl_bus[103] !== 1'b1 || mem_ctrl_bus[32] !== 1'b0)
            $display("[TB] FAIL misaligned got req=%b rv=%b ale=%b wen=%b want 0 1 1 0",
                     data_req, right_valid, mem_ctrl_bus[103], mem_ctrl_bus[32]);
        else pass_count++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [103:0] held;
        right_ready = 1;
        for (int i = 0; i < 4; i++) begin
            ex_ctrl_bus = make_bus(10'h010, 1'b1, 32'h400 + 32'(i * 4), 5'(i + 1), 1'b1, 32'h0, $urandom);
            e = model(ex_ctrl_bus, 32'h0);
            left_valid = 1;
            @(posedge clk); #1;
            total_count++;
            if (right_valid !== 1'b1 || left_ready !== 1'b1 || mem_ctrl_bus !== e.bus)
                $display("[TB] FAIL b2b_%0d got rv=%b lr=%b bus=%h want 1 1 %h",
                         i, right_valid, left_ready, mem_ctrl_bus, e.bus);
            else pass_count++;
        end
        held = e.bus;
        right_ready = 0;
        ex_ctrl_bus = make_bus(10'h011, 1'b1, 32'h500, 5'd30, 1'b1, 32'h0, 32'h55);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total_count++;
            if (right_valid !== 1'b1 || left_ready !== 1'b0 || mem_ctrl_bus !== held)
                $display("[TB] FAIL stall_%0d got rv=%b lr=%b bus=%h want 1 0 %h",
                         i, right_valid, left_ready, mem_ctrl_bus, held);
            else pass_count++;
        end
        left_valid = 0; right_ready = 1;
        @(posedge clk); #1;
        total_count++;
        if (right_valid !== 1'b0 || left_ready !== 1'b1)
            $display("[TB] FAIL drain got rv=%b lr=%b want 0 1", right_valid, left_ready);
        else pass_count++;
    endtask

    task automatic test_random();
        exp_t e;
        logic [9:0] op;
        logic [31:0] addr, rd;
        int sel, delay;
        right_ready = 1;
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: op = 10'h0A0; 1: op = 10'h0A1; 2: op = 10'h0A2; 3: op = 10'h0A8;
                4: op = 10'h0A9; 5: op = 10'h0A4; 6: op = 10'h0A5; 7: op = 10'h0A6;
                default: op = 10'($urandom);
            endcase
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = (op == 10'h0A1 || op == 10'h0A5) ? {addr[1], 1'b0} : 2'b00;
            if (op == 10'h0A0 || op == 10'h0A4 || op == 10'h0A8) addr = $urandom;
            rd = $urandom;
            ex_ctrl_bus = make_bus(op, ($urandom_range(0, 7) != 0), $urandom, 5'($urandom),
                                   1'($urandom), $urandom, addr);
            e = model(ex_ctrl_bus, rd);
            left_valid = 1;
            @(posedge clk); #1;
            left_valid = 0;
            if (e.mem) begin
                delay = int'($urandom_range(0, 3));
                for (int i = 0; i <= delay; i++) begin
                    total_count++;
                    if (data_req !== 1'b1 || data_addr !== e.addr || data_wstrb !== e.strb ||
                        data_wdata !== e.wdm || right_valid !== 1'b0 || left_ready !== 1'b0)
                        $display("[TB] FAIL rnd_port_%0d got req=%b addr=%h strb=%h wd=%h rv=%b want 1 %h %h %h 0",
                                 n, data_req, data_addr, data_wstrb, data_wdata, right_valid, e.addr, e.strb, e.wdm);
                    else pass_count++;
                    if (i == delay) begin data_ack = 1; data_rdata = rd; end
                    @(posedge clk); #1;
                end
                data_ack = 0;
            end else begin
                total_count++;
                if (data_req !== 1'b0)
                    $display("[TB] FAIL rnd_noreq_%0d got req=%b want 0", n, data_req);
                else pass_count++;
            end
            total_count++;
            if (right_valid !== 1'b1 || mem_ctrl_bus !== e.bus)
                $display("[TB] FAIL rnd_result_%0d got rv=%b bus=%h want 1 %h", n, right_valid, mem_ctrl_bus, e.bus);
            else pass_count++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_access();
        ex_ctrl_bus = make_bus(10'h0A2, 1'b1, 32'h600, 5'd4, 1'b1, 32'h0, 32'h4000);
        left_valid = 1; right_ready = 1;
        @(posedge clk); #1;
        left_valid = 0;
        total_count++;
        if (data_req !== 1'b1)
            $display("[TB] FAIL rst_acc_req got %b want 1", data_req);
        else pass_count++;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        total_count++;
        if (data_req !== 1'b0 || right_valid !== 1'b0)
            $display("[TB] FAIL rst_acc_drop got req=%b rv=%b want 0 0", data_req, right_valid);
        else pass_count++;
        data_ack = 1; data_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        data_ack = 0;
        total_count++;
        if (data_req !== 1'b0 || right_valid !== 1'b0 || left_ready !== 1'b1)
            $display("[TB] FAIL late_ack got req=%b rv=%b lr=%b want 0 0 1", data_req, right_valid, left_ready);
        else pass_count++;
    endtask

    initial begin
        pass_count = 0;
        total_count = 0;
        test_reset();
        test_add();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_reset_in_access();
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
